uadd_collect: RTL and testbench
===============================

UADD_COLLECT -- requirements
Module: uadd_collect

Interface
REQ-001 Parameter: WIDTH, 32, full operand/result width.
REQ-002 Parameter: WADD, 12, chunk width produced per adder cycle.
REQ-003 Derived localparams SHALL be: NCYC = ceil(WIDTH/WADD); LASTW = WIDTH-(NCYC-1)*WADD, the valid bits in the final chunk.
REQ-004 Single clock, reset synchronous and active-high; clock and reset ports SHALL be named clk and rst.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  new adder operation begins; same pulse that starts the upstream adder.
REQ-008 op  input  3  adderOp_t encoding: ADD=010, SUB=011, EQ=000, NE=001, LT=100, GE=101, LTU=110, GEU=111.
REQ-009 chunk_valid  input  1  one adder chunk result present this cycle.
REQ-010 chunk_sum  input  WADD  chunk sum, LSB chunk first; only low LASTW bits meaningful on final chunk.
REQ-011 chunk_cout  input  1  carry out of top valid bit of current chunk; sampled on final chunk only.
REQ-012 a_msb, b_msb  input  1 each  sign bits of src_a and un-inverted src_b; sampled on final chunk.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_valid  output  1  result and cond valid.
REQ-015 result  output  WIDTH  assembled sum/difference.
REQ-016 cond  output  1  comparison outcome.
REQ-017 cout  output  1  final carry out.
REQ-018 busy  output  1  high when not IDLE.

Function
REQ-019 FSM SHALL have states IDLE, COLLECT, DONE; busy = (state != IDLE); res_valid = (state == DONE).
REQ-020 IDLE: start=1 -> latch op, chunk index idx=0, zero accumulator=1, go COLLECT; chunk_valid ignored.
REQ-021 COLLECT: on chunk_valid, write chunk_sum into result[idx*WADD +: WADD] (truncated to LASTW on idx=NCYC-1), AND zero accumulator with (valid chunk bits == 0), idx++.
REQ-022 COLLECT: cycles without chunk_valid SHALL hold all state; start SHALL be ignored.
REQ-023 Final chunk (idx==NCYC-1 with chunk_valid): capture cout, compute cond, go DONE; res_valid asserts the cycle after the final beat.
REQ-024 sum_msb = final chunk bit LASTW-1; ovf = (a_msb != b_msb) & (sum_msb != a_msb).
REQ-025 cond SHALL be: EQ zero; NE !zero; LT sum_msb^ovf; GE !(sum_msb^ovf); LTU !cout; GEU cout; ADD/SUB 0.
REQ-026 DONE: result, cond, cout held stable until handshake; chunk_valid ignored.
REQ-027 DONE with res_ready=1: start=1 -> latch new op, go COLLECT (back-to-back, no IDLE bubble); start=0 -> IDLE.
REQ-028 result, cond, cout SHALL retain last values in IDLE until the next final chunk overwrites them.
REQ-029 idx SHALL never exceed NCYC-1; chunk_valid beyond NCYC beats is impossible by FSM exit.

Reset
REQ-030 rst=1 SHALL force state IDLE, idx 0, result 0, cond 0, cout 0, res_valid 0, busy 0, zero accumulator 1.
REQ-031 rst mid-COLLECT or in DONE SHALL discard the partial/pending operation; rst has priority over start, chunk_valid and res_ready.

Verification (WIDTH=32, WADD=12)
REQ-032 ADD: start, chunks 0x234, 0x001, 0x00, cout 0 -> res_valid one cycle after beat 3, result 0x00001234, cond 0.
REQ-033 EQ: three zero chunks -> cond 1; NE with chunk1=0x010 -> cond 1, result 0x00010000.
REQ-034 LT/LTU a=0xFFFFFFFF, b=1: chunks 0xFFE, 0xFFF, 0xFF, a_msb 1, b_msb 0, cout 1 -> LT cond 1; LTU cond 0.
REQ-035 LT overflow a=0x80000000, b=1: chunks 0xFFF, 0xFFF, 0x7F, a_msb 1, b_msb 0 -> ovf 1, cond 1, result 0x7FFFFFFF.
REQ-036 Backpressure: res_ready low 5 cycles with spurious chunk_valid -> outputs unchanged; then res_ready=1 with start=1 -> next cycle COLLECT, busy 1, res_valid 0.
REQ-037 rst after 2 of 3 beats -> busy 0, res_valid 0, result 0 next cycle; subsequent ADD completes correctly.

Source files
------------

// File: rtl/uadd_collect_if.sv
// rtl/uadd_collect_if.sv - chunk input, result output and handshake signals of uadd_collect
interface uadd_collect_if #(
  parameter int WIDTH = 32,
  parameter int WADD  = 12
);
  logic             start;
  logic [2:0]       op;
  logic             chunk_valid;
  logic [WADD-1:0]  chunk_sum;
  logic             chunk_cout;
  logic             a_msb;
  logic             b_msb;
  logic             res_ready;
  logic             res_valid;
  logic [WIDTH-1:0] result;
  logic             cond;
  logic             cout;
  logic             busy;

  modport master (
    output start, op, chunk_valid, chunk_sum, chunk_cout, a_msb, b_msb, res_ready,
    input  res_valid, result, cond, cout, busy
  );

  modport slave (
    input  start, op, chunk_valid, chunk_sum, chunk_cout, a_msb, b_msb, res_ready,
    output res_valid, result, cond, cout, busy
  );
endinterface

// File: rtl/uadd_collect.sv
// rtl/uadd_collect.sv - assembles chunked adder sums into a full result and comparison outcome
module uadd_collect #(
  parameter int WIDTH = 32,
  parameter int WADD  = 12
) (
  input logic          clk,
  input logic          rst,
  uadd_collect_if.slave bus
);
  localparam int NCYC  = (WIDTH + WADD - 1) / WADD;
  localparam int LASTW = WIDTH - (NCYC - 1) * WADD;
  localparam int IDXW  = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDXW-1:0]  r_idx;
  logic [2:0]       r_op;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_cond;
  logic             r_cout;

  logic             w_beat;
  logic             w_last;
  logic             w_final;
  logic             w_launch;
  logic             w_chunk_zero;
  logic             w_zero_next;
  logic             w_sum_msb;
  logic             w_ovf;
  logic             w_cond;
  logic [WIDTH-1:0] w_acc_next;

  assign w_beat   = (r_state == S_COLLECT) && bus.chunk_valid;
  assign w_last   = (r_idx == IDXW'(NCYC - 1));
  assign w_final  = w_beat && w_last;
  assign w_launch = bus.start && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.res_ready));

  // Only the low LASTW bits of the final chunk count towards the zero flag and sign.
  assign w_chunk_zero = w_last ? (bus.chunk_sum[LASTW-1:0] == '0) : (bus.chunk_sum == '0);
  assign w_zero_next  = r_zero && w_chunk_zero;
  assign w_sum_msb    = bus.chunk_sum[LASTW-1];
  assign w_ovf        = (bus.a_msb != bus.b_msb) && (w_sum_msb != bus.a_msb);

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < NCYC - 1; k++) begin
      if (r_idx == IDXW'(k)) w_acc_next[k*WADD +: WADD] = bus.chunk_sum;
    end
    if (w_last) w_acc_next[WIDTH-1 -: LASTW] = bus.chunk_sum[LASTW-1:0];
  end

  always_comb begin
    w_cond = 1'b0;
    case (r_op)
      3'b000:  w_cond = w_zero_next;
      3'b001:  w_cond = !w_zero_next;
      3'b100:  w_cond = w_sum_msb ^ w_ovf;
      3'b101:  w_cond = !(w_sum_msb ^ w_ovf);
      3'b110:  w_cond = !bus.chunk_cout;
      3'b111:  w_cond = bus.chunk_cout;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_state_next = S_COLLECT;
      S_COLLECT: if (w_final) w_state_next = S_DONE;
      S_DONE:    if (bus.res_ready) w_state_next = bus.start ? S_COLLECT : S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Published outputs change only on a final beat, so they persist through IDLE and the next COLLECT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_op     <= '0;
      r_zero   <= 1'b1;
      r_acc    <= '0;
      r_result <= '0;
      r_cond   <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_launch) begin
      r_op   <= bus.op;
      r_idx  <= '0;
      r_zero <= 1'b1;
    end else if (w_beat) begin
      r_acc  <= w_acc_next;
      r_zero <= w_zero_next;
      if (w_final) begin
        r_idx    <= '0;
        r_result <= w_acc_next;
        r_cond   <= w_cond;
        r_cout   <= bus.chunk_cout;
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.cond      = r_cond;
  assign bus.cout      = r_cout;
endmodule

// File: tb/tb_uadd_collect.sv
// tb/tb_uadd_collect.sv - randomized scoreboard bench for uadd_collect
module tb_uadd_collect;
  localparam logic [2:0] OP_EQ = 3'b000, OP_NE = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011;
  localparam logic [2:0] OP_LT = 3'b100, OP_GE = 3'b101, OP_LTU = 3'b110, OP_GEU = 3'b111;

  typedef struct {
    logic [31:0] result;
    logic        cond;
    logic        cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  uadd_collect_if #(.WIDTH(32), .WADD(12)) bus ();
  uadd_collect #(.WIDTH(32), .WADD(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: ADD is a+b, every other op is a-b; comparisons evaluated directly on the operands.
  function automatic logic [32:0] ref_sum(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD) return {1'b0, a} + {1'b0, b};
    return {1'b0, a} + {1'b0, ~b} + 33'd1;
  endfunction

  function automatic logic ref_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_EQ:   return a == b;
      OP_NE:   return a != b;
      OP_LT:   return $signed(a) < $signed(b);
      OP_GE:   return $signed(a) >= $signed(b);
      OP_LTU:  return a < b;
      OP_GEU:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.res_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: res_valid with result 0x%08h but nothing expected", bus.result);
      end else begin
        if (bus.result !== sb[0].result || bus.cond !== sb[0].cond || bus.cout !== sb[0].cout) begin
          n_fail++;
          $display("FAIL sb_result: got result=0x%08h cond=%0b cout=%0b expected result=0x%08h cond=%0b cout=%0b",
                   bus.result, bus.cond, bus.cout, sb[0].result, sb[0].cond, sb[0].cout);
        end
        if (bus.res_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic start_op(input logic [2:0] op);
    bus.start = 1'b1;
    bus.op    = op;
    tick();
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
  endtask

  // Drives nbeats chunks of the operation, with optional idle gaps carrying junk and stray start pulses.
  task automatic send_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int nbeats, input bit gaps);
    logic [32:0] s;
    logic [35:0] ext;
    exp_t        e;
    s   = ref_sum(op, a, b);
    ext = {4'h0, s[31:0]};
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
          bus.chunk_valid = 1'b0;
          bus.chunk_sum   = 12'($urandom);
          bus.start       = 1'($urandom);
          bus.op          = 3'($urandom);
          tick();
        end
      end
      bus.start       = 1'b0;
      bus.chunk_valid = 1'b1;
      bus.chunk_sum   = ext[k*12 +: 12];
      bus.chunk_cout  = 1'($urandom);
      bus.a_msb       = 1'($urandom);
      bus.b_msb       = 1'($urandom);
      if (k == 2) begin
        bus.chunk_sum[11:8] = 4'($urandom);
        bus.chunk_cout      = s[32];
        bus.a_msb           = a[31];
        bus.b_msb           = b[31];
        e.result = s[31:0];
        e.cond   = ref_cond(op, a, b);
        e.cout   = s[32];
        sb.push_back(e);
      end
      tick();
    end
    bus.chunk_valid = 1'b0;
    if (nbeats == 3) begin
      chk("latency_res_valid", 32'(bus.res_valid), 32'd1);
    end else begin
      chk("partial_busy", 32'(bus.busy), 32'd1);
      chk("partial_res_valid", 32'(bus.res_valid), 32'd0);
    end
  endtask

  // Holds DONE for stall cycles with junk on the chunk inputs, then handshakes.
  task automatic finish_op(input int stall, input bit b2b, input logic [2:0] nop);
    for (int i = 0; i < stall; i++) begin
      bus.res_ready   = 1'b0;
      bus.chunk_valid = 1'($urandom);
      bus.chunk_sum   = 12'($urandom);
      bus.start       = 1'($urandom);
      tick();
    end
    bus.chunk_valid = 1'b0;
    bus.res_ready   = 1'b1;
    bus.start       = b2b;
    bus.op          = nop;
    tick();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    chk("post_hs_busy", 32'(bus.busy), 32'(b2b));
    chk("post_hs_res_valid", 32'(bus.res_valid), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_op(op);
    send_op(op, a, b, 3, 1'b0);
    finish_op(0, 1'b0, 3'b000);
  endtask

  initial begin
    logic [2:0]  cur_op;
    logic [2:0]  nop;
    logic [31:0] a;
    logic [31:0] b;
    bit          b2b;
    bit          started;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.chunk_valid = 1'b0; bus.chunk_sum = '0;
    bus.chunk_cout = 1'b0; bus.a_msb = 1'b0; bus.b_msb = 1'b0; bus.res_ready = 1'b0;
    tick(); tick();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_cond", 32'(bus.cond), 32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    tick();

    run_op(OP_ADD, 32'h0000_1234, 32'h0);
    run_op(OP_EQ,  32'h0000_0005, 32'h0000_0005);
    run_op(OP_NE,  32'h0001_0000, 32'h0);
    run_op(OP_LT,  32'hFFFF_FFFF, 32'h1);
    run_op(OP_LTU, 32'hFFFF_FFFF, 32'h1);
    run_op(OP_LT,  32'h8000_0000, 32'h1);
    run_op(OP_GEU, 32'h0000_0000, 32'hFFFF_FFFF);

    start_op(OP_GE);
    send_op(OP_GE, 32'h7FFF_FFFF, 32'h8000_0000, 3, 1'b1);
    finish_op(5, 1'b1, OP_ADD);
    send_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 3, 1'b0);
    finish_op(0, 1'b0, 3'b000);

    start_op(OP_ADD);
    send_op(OP_ADD, 32'h1111_1111, 32'h2222_2222, 2, 1'b0);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.chunk_valid = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.chunk_valid = 1'b0;
    bus.res_ready = 1'b0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_mid_result", bus.result, 32'd0);
    run_op(OP_ADD, 32'h0ABC_DEF0, 32'h1234_5678);

    started = 1'b0;
    cur_op  = OP_ADD;
    for (int i = 0; i < 40; i++) begin
      if (!started) begin
        cur_op = 3'($urandom);
        start_op(cur_op);
      end
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      send_op(cur_op, a, b, 3, 1'b1);
      b2b = (i < 39) ? 1'($urandom) : 1'b0;
      nop = 3'($urandom);
      finish_op(int'($urandom_range(0, 3)), b2b, nop);
      started = b2b;
      cur_op  = nop;
      if (!b2b) begin
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
          bus.chunk_valid = 1'($urandom);
          bus.chunk_sum   = 12'($urandom);
          tick();
        end
        bus.chunk_valid = 1'b0;
      end
    end

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
